// File: rtl/logthief_sequencer_if.sv
// Command, capture-buffer and readout signals of the logthief sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface logthief_sequencer_if #(
    parameter int LOGTHIEF_DATA_WIDTH = 192
);
    logic [31:0]                    sw_cmd_i;
    logic                           sw_cmd_valid_i;
    logic [LOGTHIEF_DATA_WIDTH-1:0] CORE0_data_i;
    logic [LOGTHIEF_DATA_WIDTH-1:0] CORE1_data_i;
    logic [31:0]                    cmd_o;
    logic [31:0]                    addr_o;
    logic [31:0]                    rd_word_o;
    logic                           rd_valid_o;
    logic                           rd_ready_i;
    logic                           rd_last_o;
    logic                           busy_o;
    logic                           done_o;
    logic [2:0]                     state_o;

    modport slave (
        input  sw_cmd_i, sw_cmd_valid_i, CORE0_data_i, CORE1_data_i, rd_ready_i,
        output cmd_o, addr_o, rd_word_o, rd_valid_o, rd_last_o, busy_o, done_o, state_o
    );

    modport master (
        output sw_cmd_i, sw_cmd_valid_i, CORE0_data_i, CORE1_data_i, rd_ready_i,
        input  cmd_o, addr_o, rd_word_o, rd_valid_o, rd_last_o, busy_o, done_o, state_o
    );
endinterface

// File: rtl/logthief_sequencer.sv
// Software-driven sequencer: clears/arms the dual-core capture block and dumps
// one bank of the capture buffer as a stream of 32-bit words.
module logthief_sequencer #(
    parameter int LOGTHIEF_DATA_WIDTH = 192,
    parameter int LOGTHIEF_LOG2_DEEP  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    logthief_sequencer_if.slave   bus
);
    localparam int WORDS = LOGTHIEF_DATA_WIDTH / 32;
    localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);
    localparam logic [LOGTHIEF_LOG2_DEEP-1:0] LAST_INDEX = '1;
    localparam logic [31:0] CMD_CLEAR = 32'hDEAD_DEAD;
    localparam logic [31:0] CMD_ARM   = 32'hDEAD_CAFE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARMED   = 3'd2,
        DONE    = 3'd3,
        RD_ADDR = 3'd4,
        RD_WAIT = 3'd5,
        RD_SEND = 3'd6
    } state_t;

    state_t                           state_reg, state_next;
    logic [LOGTHIEF_LOG2_DEEP-1:0]    index_reg, index_next;
    logic [2:0]                       word_reg, word_next;
    logic                             bank_reg, bank_next;
    logic [LOGTHIEF_DATA_WIDTH-1:0]   hold_reg, hold_next;
    logic [31:0]                      hold_words [WORDS];

    logic is_clear, is_arm, is_dump, handshake, both_full;

    assign is_clear  = bus.sw_cmd_valid_i && (bus.sw_cmd_i == CMD_CLEAR);
    assign is_arm    = bus.sw_cmd_valid_i && (bus.sw_cmd_i == CMD_ARM);
    // Only 0xBEEF0000 and 0xBEEF0001 are dumps; bit 0 selects the bank.
    assign is_dump   = bus.sw_cmd_valid_i && (bus.sw_cmd_i[31:1] == 31'h5F77_8000);
    assign handshake = (state_reg == RD_SEND) && bus.rd_ready_i;
    assign both_full = bus.CORE0_data_i[LOGTHIEF_DATA_WIDTH-1]
                    && bus.CORE1_data_i[LOGTHIEF_DATA_WIDTH-1];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign hold_words[gi] = hold_reg[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            index_reg <= '0;
            word_reg  <= '0;
            bank_reg  <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            word_reg  <= word_next;
            bank_reg  <= bank_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        word_next  = word_reg;
        bank_next  = bank_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (is_arm) begin
                    state_next = ARMED;
                end else if (is_dump) begin
                    state_next = RD_ADDR;
                    bank_next  = bus.sw_cmd_i[0];
                    index_next = '0;
                    word_next  = '0;
                end
            end
            CLEAR:   state_next = IDLE;
            ARMED:   if (both_full) state_next = DONE;
            RD_ADDR: state_next = RD_WAIT;
            RD_WAIT: begin
                state_next = RD_SEND;
                hold_next  = bank_reg ? bus.CORE1_data_i : bus.CORE0_data_i;
            end
            RD_SEND: begin
                if (handshake) begin
                    if (word_reg == LAST_WORD) begin
                        word_next = '0;
                        if (index_reg == LAST_INDEX) begin
                            state_next = DONE;
                        end else begin
                            index_next = index_reg + LOGTHIEF_LOG2_DEEP'(1);
                            state_next = RD_ADDR;
                        end
                    end else begin
                        word_next = word_reg + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A clear overrides whatever the current state decided, including a handshake.
        if (is_clear) begin
            state_next = CLEAR;
            word_next  = '0;
        end
    end

    always_comb begin
        case (state_reg)
            CLEAR:   bus.cmd_o = CMD_CLEAR;
            ARMED:   bus.cmd_o = CMD_ARM;
            default: bus.cmd_o = 32'h0;
        endcase
    end

    assign bus.addr_o     = 32'(index_reg);
    assign bus.rd_valid_o = (state_reg == RD_SEND);
    assign bus.rd_word_o  = bus.rd_valid_o ? hold_words[word_reg] : 32'h0;
    assign bus.rd_last_o  = (state_reg == RD_SEND) && (word_reg == LAST_WORD)
                         && (index_reg == LAST_INDEX);
    assign bus.busy_o     = !((state_reg == IDLE) || (state_reg == DONE));
    assign bus.done_o     = (state_reg == DONE);
    assign bus.state_o    = state_reg;
endmodule

// File: doc/logthief_sequencer.md
LOGTHIEF_SEQUENCER -- requirements
Module: logthief_sequencer

Interface
REQ-001 SHALL have parameter LOGTHIEF_DATA_WIDTH, default 192, width of one captured entry per core.
REQ-002 SHALL have parameter LOGTHIEF_LOG2_DEEP, default 8, log2 of capture depth (256 entries).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous active-high reset.
REQ-005 SHALL have port sw_cmd_i  input  32  software command word.
REQ-006 SHALL have port sw_cmd_valid_i  input  1  one-cycle strobe qualifying sw_cmd_i.
REQ-007 SHALL have port CORE0_data_i  input  LOGTHIEF_DATA_WIDTH  capture-buffer read data, core 0; bit 191 = capture-full status.
REQ-008 SHALL have port CORE1_data_i  input  LOGTHIEF_DATA_WIDTH  same, core 1.
REQ-009 SHALL have port cmd_o  output  32  command driven to the capture block.
REQ-010 SHALL have port addr_o  output  32  capture-buffer read address; upper 24 bits always 0.
REQ-011 SHALL have port rd_word_o  output  32  readout word.
REQ-012 SHALL have port rd_valid_o  output  1  rd_word_o valid.
REQ-013 SHALL have port rd_ready_i  input  1  consumer accepts rd_word_o.
REQ-014 SHALL have port rd_last_o  output  1  marks last word of a bank dump.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE and DONE.
REQ-016 SHALL have port done_o  output  1  high in DONE.
REQ-017 SHALL have port state_o  output  3  current state encoding (IDLE=0, CLEAR=1, ARMED=2, DONE=3, RD_ADDR=4, RD_WAIT=5, RD_SEND=6).

Function
REQ-018 SHALL decode commands only on sw_cmd_valid_i: 0xDEADDEAD = CLEAR, 0xDEADCAFE = ARM, 0xBEEF000x = DUMP with bank = sw_cmd_i[0]; other values ignored.
REQ-019 CLEAR SHALL be accepted in every state, abort any operation, drop rd_valid_o next cycle, and enter CLEAR.
REQ-020 CLEAR state SHALL drive cmd_o = 0xDEADDEAD for exactly 1 cycle, then go to IDLE.
REQ-021 ARM SHALL be accepted only in IDLE or DONE; go to ARMED.
REQ-022 ARMED SHALL hold cmd_o = 0xDEADCAFE until CORE0_data_i[191] and CORE1_data_i[191] are both 1, then enter DONE next cycle.
REQ-023 In IDLE, DONE and all readout states cmd_o SHALL be 0x00000000.
REQ-024 DUMP SHALL be accepted only in IDLE or DONE; latch bank, set entry index to 0, enter RD_ADDR; ARM or DUMP in other states ignored.
REQ-025 RD_ADDR SHALL drive addr_o = entry index for one cycle, then RD_WAIT (one cycle for buffer read latency), then RD_SEND.
REQ-026 On RD_WAIT→RD_SEND the selected bank's data (CORE0 when bank=0, CORE1 when bank=1) SHALL be latched into a 192-bit holding register; addr_o held stable through RD_WAIT.
REQ-027 RD_SEND SHALL present six 32-bit words, bits [31:0] first through [191:160] last, one per accepted handshake.
REQ-028 rd_valid_o SHALL stay high and rd_word_o stable until rd_valid_o & rd_ready_i; word advances on that cycle only.
REQ-029 After word 5 is accepted: if index < 255, index increments and state returns to RD_ADDR; if index = 255, state goes to DONE (no wrap to 0).
REQ-030 rd_last_o SHALL be high only with word 5 of entry 255.
REQ-031 Index and word counters SHALL be unsigned, LOGTHIEF_LOG2_DEEP and 3 bits respectively.
REQ-032 CLEAR strobe coinciding with an accepting handshake SHALL win: no further words, state CLEAR.

Reset
REQ-033 reset_i SHALL asynchronously force state IDLE, cmd_o = 0, addr_o = 0, rd_word_o = 0, rd_valid_o = 0, rd_last_o = 0, busy_o = 0, done_o = 0, counters and bank to 0.
REQ-034 Reset asserted mid-dump SHALL discard the holding register; after release no word is emitted until a new DUMP.

Verification
REQ-035 Reset release, sw CLEAR -> cmd_o = 0xDEADDEAD for 1 cycle, state_o 1 then 0.
REQ-036 ARM, status bits raised core0 at cycle 10, core1 at cycle 20 -> cmd_o = 0xDEADCAFE until cycle 20, done_o = 1 from cycle 21.
REQ-037 DUMP bank 1 with rd_ready_i always 1, entry n data = {n repeated} -> 1536 words, rd_last_o only on the last, addr_o 0..255, then done_o = 1.
REQ-038 DUMP bank 0 with rd_ready_i toggling 1-of-3 cycles -> words stable while stalled, no loss or duplication, word order [31:0] first.
REQ-039 CLEAR issued at entry 7 word 3 of a dump -> rd_valid_o low next cycle, cmd_o = 0xDEADDEAD one cycle, IDLE.
REQ-040 ARM during RD_SEND and reset_i pulse mid-ARMED -> ARM ignored; reset gives all outputs 0, state_o = 0 immediately.
